// File: rtl/dmem_bank_sync.sv
// dmem_bank_sync -- clocked data memory with per-byte write enables,
// registered 1-cycle reads, out-of-range detection and a post-reset init
// sequencer that fills word i with i*INIT_STEP.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   memread    read request, sampled at posedge
//   memwrite   write request, sampled at posedge
//   address    byte address; word index = address >> OFS_W
//   byteen     per-byte write enable (bit k -> writedata byte k)
//   writedata  write data
//   readdata   read data, valid when rvalid=1; holds otherwise
//   rvalid     one-cycle pulse, read data valid
//   err        one-cycle pulse, accepted access was out of range
//   ready      init sequence finished, accesses accepted
module dmem_bank_sync #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 128,
  parameter int INIT_STEP = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [31:0]           address,
  input  logic [DATA_W/8-1:0]   byteen,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  rvalid,
  output logic                  err,
  output logic                  ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic [DATA_W-1:0] init_val;
  logic              init_last;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]       word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              accept;
  logic              do_read;
  logic              do_write;

  // Address decode: range compare uses the full-width index so high
  // address bits can never alias onto a valid word.
  always_comb begin
    word_idx = address >> OFS_W;
    mem_idx  = word_idx[IDX_W-1:0];
    in_range = (word_idx < 32'(DEPTH));
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    init_last = (init_cnt == IDX_W'(DEPTH - 1));
    case (state)
      ST_INIT: begin
        if (init_last) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  always_comb begin
    accept   = ready & (memread | memwrite);
    do_read  = accept & memread;
    do_write = accept & memwrite & in_range & rst_n;
  end

  // State register and init counters. The fill value is kept as a running
  // sum (+INIT_STEP per word) instead of init_cnt*INIT_STEP; both wrap
  // modulo 2^DATA_W identically.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      init_val <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        init_val <= init_val + DATA_W'(INIT_STEP);
      end
    end
  end

  // Storage: not reset; the init sequence rewrites every word.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_INIT)) begin
      mem[init_cnt] <= init_val;
    end else if (do_write) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (byteen[k]) begin
          mem[mem_idx][8*k +: 8] <= writedata[8*k +: 8];
        end
      end
    end
  end

  // Registered read path. Nonblocking semantics give read-first behaviour
  // when a read and write hit the same word in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readdata <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= do_read;
      err    <= accept & ~in_range;
      if (do_read) begin
        readdata <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bank_sync.sv
module tb_dmem_bank_sync;

  localparam int DEPTH     = 128;
  localparam int INIT_STEP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        rvalid;
  logic        err;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain word array plus the expected held read value.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rd;

  dmem_bank_sync #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .INIT_STEP (INIT_STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .byteen    (byteen),
    .writedata (writedata),
    .readdata  (readdata),
    .rvalid    (rvalid),
    .err       (err),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reset, then run the init sequence with junk requests applied; they must
  // be ignored. abort_at >= 0 stops after that many init cycles.
  task automatic do_reset(input int abort_at);
    int cyc;
    rst_n = 1'b0;
    memread = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.readdata", readdata, 32'd0);
    exp_rd = '0;
    rst_n = 1'b1;
    memread = 1'b1;
    memwrite = 1'b1;
    address = 32'h0000_0000;
    byteen = 4'hF;
    writedata = $urandom;
    cyc = 0;
    while (!ready && cyc < DEPTH + 8 && cyc != abort_at) begin
      @(negedge clk);
      cyc++;
      check("init.rvalid", 32'(rvalid), 32'd0);
      check("init.err", 32'(err), 32'd0);
    end
    memread = 1'b0;
    memwrite = 1'b0;
    if (abort_at < 0) begin
      check("init.len", 32'(cyc), 32'(DEPTH));
      check("init.ready", 32'(ready), 32'd1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i * INIT_STEP);
    end
  endtask

  // One access cycle, driven at a negedge and checked at the next one.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
    logic [31:0] idx;
    bit inr;
    bit exp_rv;
    bit exp_er;
    memread = rd;
    memwrite = wr;
    address = addr;
    byteen = be;
    writedata = wd;
    idx = addr >> 2;
    inr = (idx < DEPTH);
    exp_rv = rd;
    exp_er = (rd || wr) && !inr;
    if (rd) exp_rd = inr ? ref_mem[idx] : 32'h0;
    if (wr && inr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      end
    end
    @(negedge clk);
    memread = 1'b0;
    memwrite = 1'b0;
    check({tag, ".rvalid"}, 32'(rvalid), 32'(exp_rv));
    check({tag, ".err"}, 32'(err), 32'(exp_er));
    check({tag, ".readdata"}, readdata, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    int r;

    // T1: init length and fill values
    do_reset(-1);
    access("t1.rd0", 1, 0, 32'h0, 4'h0, 32'h0);
    check("t1.val0", readdata, 32'd0);
    access("t1.rd1", 1, 0, 32'h4, 4'h0, 32'h0);
    check("t1.val1", readdata, 32'd10);
    access("t1.rd127", 1, 0, 32'd508, 4'h0, 32'h0);
    check("t1.val127", readdata, 32'd1270);

    // T2: idle holds readdata, then read of 0x1FC
    access("t2.idle", 0, 0, 32'h0, 4'h0, 32'h0);
    access("t2.rd", 1, 0, 32'h1FC, 4'h0, 32'h0);
    check("t2.val", readdata, 32'd1270);

    // T3: partial byte write
    access("t3.wr", 0, 1, 32'd20, 4'b0101, 32'hAABBCCDD);
    access("t3.rd", 1, 0, 32'd21, 4'h0, 32'h0);
    check("t3.val", readdata, 32'h00BB00DD);
    access("t3.wr0", 0, 1, 32'd20, 4'b0000, 32'h11111111);
    access("t3.rd0", 1, 0, 32'd20, 4'h0, 32'h0);

    // T4: read-first on simultaneous read+write, back-to-back
    access("t4.rw", 1, 1, 32'd12, 4'hF, 32'hDEADBEEF);
    check("t4.old", readdata, 32'd30);
    access("t4.rd", 1, 0, 32'd12, 4'h0, 32'h0);
    check("t4.new", readdata, 32'hDEADBEEF);

    // T5: out of range, no aliasing
    access("t5.rd", 1, 0, 32'h200, 4'h0, 32'h0);
    check("t5.err", 32'(err), 32'd1);
    access("t5.wr", 0, 1, 32'h200, 4'hF, 32'h5A5A5A5A);
    access("t5.rw", 1, 1, 32'h8000_0004, 4'hF, 32'h12345678);
    access("t5.rd0", 1, 0, 32'h0, 4'h0, 32'h0);
    check("t5.val0", readdata, 32'd0);
    access("t5.rd1", 1, 0, 32'h4, 4'h0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      else if (r == 8) a = 32'((DEPTH + $urandom_range(0, 7)) * 4);
      else a = $urandom | 32'h8000_0000;
      access("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
             4'($urandom_range(0, 15)), $urandom);
    end

    // T6: reset during a read, and reset mid-INIT
    memread = 1'b1;
    address = 32'd12;
    rst_n = 1'b0;
    @(negedge clk);
    memread = 1'b0;
    check("t6.rd_rvalid", 32'(rvalid), 32'd0);
    check("t6.rd_err", 32'(err), 32'd0);
    do_reset(40);
    check("t6.mid_ready", 32'(ready), 32'd0);
    do_reset(-1);
    access("t6.rd3", 1, 0, 32'd12, 4'h0, 32'h0);
    check("t6.val3", readdata, 32'd30);

    // Full sweep, back-to-back reads
    for (int i = 0; i < DEPTH; i++) begin
      access("sweep", 1, 0, 32'(i * 4), 4'h0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
